// File: rtl/smem_arbiter.sv
// Screen-memory write arbiter: CPU writes take strict priority over a block-fill engine.
// Define SMEM_ARB_FAIR_EN to add a guard that forces one fill slot after 4 consecutive CPU grants in FILL.
module smem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int CELL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [CELL_W-1:0] cpu_data,
  output logic              cpu_gnt,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [CELL_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              smem_wr,
  output logic [ADDR_W-1:0] smem_addr,
  output logic [CELL_W-1:0] smem_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_count;
  logic [CELL_W-1:0] r_value;
  logic [ADDR_W-1:0] w_fill_addr;
  logic              w_fill_last;
  logic              w_cpu_gnt;
  logic              w_fill_gnt;
  logic              w_fair_block;

  assign w_fill_addr = r_base + r_count;
  assign w_fill_last = (r_count == (r_len - ADDR_W'(1)));
  assign w_cpu_gnt   = cpu_req & ~reset & ~w_fair_block;
  assign w_fill_gnt  = (r_state == FILL) & ~w_cpu_gnt & ~reset;
  assign cpu_gnt     = w_cpu_gnt;
  assign fill_busy   = (r_state == FILL);
  assign fill_done   = (r_state == DONE);

`ifdef SMEM_ARB_FAIR_EN
  logic [2:0] r_fair_cnt;

  assign w_fair_block = (r_state == FILL) && (r_fair_cnt == 3'd4);

  // Run length of CPU grants that stalled the fill; any fill slot or exit from FILL restarts it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fair_cnt <= 3'd0;
    end else if ((r_state != FILL) || w_fill_gnt) begin
      r_fair_cnt <= 3'd0;
    end else if (w_cpu_gnt) begin
      r_fair_cnt <= r_fair_cnt + 3'd1;
    end
  end
`else
  assign w_fair_block = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero-length fill goes straight to the completion pulse
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (fill_start) begin
          if (fill_len != {ADDR_W{1'b0}}) begin
            w_state_nxt = FILL;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FILL: begin
        if (w_fill_gnt && w_fill_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = FILL;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fill job parameters and progress counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base  <= {ADDR_W{1'b0}};
      r_len   <= {ADDR_W{1'b0}};
      r_value <= {CELL_W{1'b0}};
      r_count <= {ADDR_W{1'b0}};
    end else if ((r_state == IDLE) && fill_start && (fill_len != {ADDR_W{1'b0}})) begin
      r_base  <= fill_base;
      r_len   <= fill_len;
      r_value <= fill_value;
      r_count <= {ADDR_W{1'b0}};
    end else if (w_fill_gnt) begin
      r_count <= r_count + ADDR_W'(1);
    end
  end

  // Registered write port; address and data hold between writes
  always_ff @(posedge clk) begin
    if (reset) begin
      smem_wr   <= 1'b0;
      smem_addr <= {ADDR_W{1'b0}};
      smem_data <= {CELL_W{1'b0}};
    end else if (w_cpu_gnt) begin
      smem_wr   <= 1'b1;
      smem_addr <= cpu_addr;
      smem_data <= cpu_data;
    end else if (w_fill_gnt) begin
      smem_wr   <= 1'b1;
      smem_addr <= w_fill_addr;
      smem_data <= r_value;
    end else begin
      smem_wr   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_smem_arbiter.sv
// Self-checking bench for smem_arbiter: a queue-based reference model of the fill job and CPU port,
// directed scenarios for the called-out cases, then randomized traffic.
module tb_smem_arbiter;
  localparam int AW = 11;
  localparam int CW = 2;
`ifdef SMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [CW-1:0] cpu_data;
  logic          cpu_gnt;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW-1:0] fill_len;
  logic [CW-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic          smem_wr;
  logic [AW-1:0] smem_addr;
  logic [CW-1:0] smem_data;

  always #5 clk = ~clk;

  smem_arbiter #(.ADDR_W(AW), .CELL_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .smem_wr(smem_wr), .smem_addr(smem_addr), .smem_data(smem_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending fill cells as a queue of addresses
  int fq[$];
  int fval = 0;
  bit m_done = 1'b0;
  int fair_run = 0;
  bit e_wr = 1'b0;
  int e_addr = 0;
  int e_data = 0;
  bit e_gnt_last = 1'b0;
  int wlog_a[$];
  int wlog_d[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock cycle: check at negedge, advance model, return just after posedge
  task automatic cycle();
    bit busy;
    bit eg;
    bit fg;
    @(negedge clk);
    busy = (fq.size() != 0);
    eg   = !reset && cpu_req && !(FAIR && busy && fair_run == 4);
    check("cpu_gnt",   32'(cpu_gnt),   32'(eg));
    check("fill_busy", 32'(fill_busy), 32'(busy));
    check("fill_done", 32'(fill_done), 32'(m_done));
    check("smem_wr",   32'(smem_wr),   32'(e_wr));
    check("smem_addr", 32'(smem_addr), e_addr);
    check("smem_data", 32'(smem_data), e_data);
    if (smem_wr === 1'b1) begin
      wlog_a.push_back(int'(smem_addr));
      wlog_d.push_back(int'(smem_data));
    end
    e_gnt_last = eg;
    if (reset) begin
      fq.delete();
      m_done = 1'b0; fair_run = 0; e_wr = 1'b0; e_addr = 0; e_data = 0;
    end else begin
      fg   = busy && !eg;
      e_wr = eg || fg;
      if (eg) begin
        e_addr = int'(cpu_addr); e_data = int'(cpu_data);
      end else if (fg) begin
        e_addr = fq.pop_front(); e_data = fval;
      end
      if (busy) fair_run = fg ? 0 : fair_run + (eg ? 1 : 0);
      else fair_run = 0;
      if (fg && fq.size() == 0) begin
        m_done = 1'b1;
      end else if (!busy && !m_done && fill_start) begin
        if (fill_len == '0) begin
          m_done = 1'b1;
        end else begin
          m_done = 1'b0;
          for (int i = 0; i < int'(fill_len); i++) fq.push_back((int'(fill_base) + i) % (1 << AW));
          fval = int'(fill_value);
        end
      end else begin
        m_done = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    fill_start = 1'b0;
  endtask

  task automatic start_fill(input int base, input int len, input int val);
    fill_start = 1'b1;
    fill_base  = AW'(base);
    fill_len   = AW'(len);
    fill_value = CW'(val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int exp043[$];
  int k;
  int n;

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Basic 3-cell fill, no CPU traffic
    wlog_a.delete(); wlog_d.delete();
    start_fill(10, 3, 2);
    idle(7);
    check("t040_nwrites", wlog_a.size(), 3);
    for (int i = 0; i < 3 && i < wlog_a.size(); i++) begin
      check("t040_addr", wlog_a[i], 10 + i);
      check("t040_data", wlog_d[i], 2);
    end

    // Address wrap at the top of the cell space
    wlog_a.delete(); wlog_d.delete();
    start_fill(2046, 4, 1);
    idle(8);
    check("t041_nwrites", wlog_a.size(), 4);
    exp043 = '{2046, 2047, 0, 1};
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) check("t041_addr", wlog_a[i], exp043[i]);

    // Zero-length fill: completion pulse, no write
    wlog_a.delete(); wlog_d.delete();
    start_fill(77, 0, 3);
    cycle();
    check("t042_done", 32'(fill_done), 32'd1);
    idle(3);
    check("t042_nwrites", wlog_a.size(), 0);

    // CPU contention during a 2-cell fill
    wlog_a.delete(); wlog_d.delete();
    start_fill(500, 2, 3);
    cycle();
    k = 0; cpu_req = 1'b1; cpu_addr = AW'(100); cpu_data = 2'd1;
    n = 0;
    while ((k < 6 || fq.size() != 0 || m_done) && n < 40) begin
      cycle();
      n++;
      if (e_gnt_last) begin
        k++;
        if (k == 6) cpu_req = 1'b0;
        else cpu_addr = AW'(100 + k);
      end
    end
    check("t043_timeout", 32'(n < 40), 32'd1);
    idle(2);
    if (FAIR) exp043 = '{100, 101, 102, 103, 500, 104, 105, 501};
    else      exp043 = '{100, 101, 102, 103, 104, 105, 500, 501};
    check("t043_nwrites", wlog_a.size(), 8);
    for (int i = 0; i < 8 && i < wlog_a.size(); i++) check("t043_order", wlog_a[i], exp043[i]);

    // Reset in the middle of a 5-cell fill
    wlog_a.delete(); wlog_d.delete();
    start_fill(300, 5, 2);
    n = 0;
    cycle();
    while (fq.size() != 3 && n < 20) begin
      cycle();
      n++;
    end
    check("t044_timeout", fq.size(), 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle(6);
    check("t044_nwrites", wlog_a.size(), 2);
    check("t044_busy", 32'(fill_busy), 32'd0);
    check("t044_done", 32'(fill_done), 32'd0);
    start_fill(600, 2, 1);
    idle(5);
    check("t044_restart", wlog_a.size(), 4);
    if (wlog_a.size() == 4) check("t044_raddr", wlog_a[3], 601);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (cpu_req && e_gnt_last) cpu_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req  = 1'b1;
        cpu_addr = AW'($urandom);
        cpu_data = CW'($urandom);
      end
      if ($urandom_range(0, 11) == 0)
        start_fill($urandom_range(0, 1) == 1 ? int'($urandom_range(2030, 2047)) : int'($urandom_range(0, 2047)),
                   int'($urandom_range(0, 12)), int'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 199) == 0);
      cycle();
      e_gnt_last = e_gnt_last && !reset;
    end
    reset = 1'b0;
    cpu_req = 1'b0;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
